// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: round-robin between the ALU and load paths,
// presenting one registered write per cycle and counting contention cycles.
module wb_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              rf_busy,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic {
    PREF_MEM = 1'b0,
    PREF_ALU = 1'b1
  } pref_t;

  pref_t             pref_q, pref_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic both_valid;
  logic alu_acc, mem_acc;

  assign both_valid = alu_valid & mem_valid;

  // Readies are gated by reset so nothing is accepted while it is held low.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (reset && !rf_busy) begin
      if (both_valid) begin
        alu_ready = (pref_q == PREF_ALU);
        mem_ready = (pref_q == PREF_MEM);
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end
  end

  assign alu_acc = alu_valid & alu_ready;
  assign mem_acc = mem_valid & mem_ready;

  always_comb begin
    pref_d    = pref_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    cnt_d     = cnt_q;
    if (mem_acc) begin
      pref_d    = PREF_ALU;
      wb_en_d   = (mem_rd != '0);
      wb_rd_d   = mem_rd;
      wb_data_d = mem_data;
    end else if (alu_acc) begin
      pref_d    = PREF_MEM;
      wb_en_d   = (alu_rd != '0);
      wb_rd_d   = alu_rd;
      wb_data_d = alu_data;
    end
    // Contention counts even while the register file is busy; saturates.
    if (both_valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pref_q    <= PREF_MEM;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      pref_q    <= pref_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wb_en        = wb_en_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign conflict_cnt = cnt_q;

endmodule
